// File: rtl/wshb_arbiter_2m.sv
// ============================================================================
// wshb_arbiter_2m : two-master Wishbone arbiter with round-robin/fixed priority
//                   and MAX_BURST ack-boundary preemption.  Rev 1.0
// ============================================================================
`default_nettype none

module wshb_arbiter_2m #(
  parameter int MAX_BURST  = 16,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_m0_cyc,
  input  logic        i_m0_stb,
  input  logic        i_m0_we,
  input  logic [31:0] i_m0_adr,
  input  logic [31:0] i_m0_dat_ms,
  input  logic [3:0]  i_m0_sel,
  input  logic [2:0]  i_m0_cti,
  input  logic [1:0]  i_m0_bte,
  output logic        o_m0_ack,
  output logic [31:0] o_m0_dat_sm,
  input  logic        i_m1_cyc,
  input  logic        i_m1_stb,
  input  logic        i_m1_we,
  input  logic [31:0] i_m1_adr,
  input  logic [31:0] i_m1_dat_ms,
  input  logic [3:0]  i_m1_sel,
  input  logic [2:0]  i_m1_cti,
  input  logic [1:0]  i_m1_bte,
  output logic        o_m1_ack,
  output logic [31:0] o_m1_dat_sm,
  output logic        o_s_cyc,
  output logic        o_s_stb,
  output logic        o_s_we,
  output logic [31:0] o_s_adr,
  output logic [31:0] o_s_dat_ms,
  output logic [3:0]  o_s_sel,
  output logic [2:0]  o_s_cti,
  output logic [1:0]  o_s_bte,
  input  logic        i_s_ack,
  input  logic [31:0] i_s_dat_sm,
  output logic [1:0]  o_owner
);

  localparam int                 c_CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [c_CNT_W-1:0] c_LIM   = c_CNT_W'(MAX_BURST - 1);

  // Encoding doubles as the one-hot owner vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_last;   // 1 = M1 was granted most recently
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_next;
  logic               w_req0;
  logic               w_req1;
  logic               w_own_stb;
  logic               w_ack_cnt;
  logic               w_limit;

  assign w_req0 = i_m0_cyc & i_m0_stb;
  assign w_req1 = i_m1_cyc & i_m1_stb;

  always_comb begin
    w_own_stb = 1'b0;
    case (r_state)
      GNT0:    w_own_stb = i_m0_stb;
      GNT1:    w_own_stb = i_m1_stb;
      default: w_own_stb = 1'b0;
    endcase
  end

  // Acks seen while the owner's stb is low are passed through but not counted.
  assign w_ack_cnt = i_s_ack & w_own_stb;
  assign w_limit   = w_ack_cnt & (r_cnt == c_LIM);

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_req0 && (!w_req1 || FIXED_PRIO || r_last)) w_next = GNT0;
        else if (w_req1)                                 w_next = GNT1;
      end
      GNT0: begin
        if (!i_m0_cyc)             w_next = w_req1 ? GNT1 : IDLE;
        else if (w_limit && w_req1) w_next = GNT1;
        else if (w_ack_cnt)        w_cnt_next = w_limit ? '0 : r_cnt + c_CNT_W'(1);
      end
      GNT1: begin
        if (!i_m1_cyc)             w_next = w_req0 ? GNT0 : IDLE;
        else if (w_limit && w_req0) w_next = GNT0;
        else if (w_ack_cnt)        w_cnt_next = w_limit ? '0 : r_cnt + c_CNT_W'(1);
      end
      default: w_next = IDLE;
    endcase
    if (w_next != r_state) w_cnt_next = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_next == GNT0)      r_last <= 1'b0;
      else if (w_next == GNT1) r_last <= 1'b1;
    end
  end

  assign o_owner     = r_state;
  assign o_m0_dat_sm = i_s_dat_sm;
  assign o_m1_dat_sm = i_s_dat_sm;

  always_comb begin
    o_s_cyc    = 1'b0;
    o_s_stb    = 1'b0;
    o_s_we     = 1'b0;
    o_s_adr    = '0;
    o_s_dat_ms = '0;
    o_s_sel    = '0;
    o_s_cti    = '0;
    o_s_bte    = '0;
    o_m0_ack   = 1'b0;
    o_m1_ack   = 1'b0;
    case (r_state)
      GNT0: begin
        o_s_cyc    = i_m0_cyc;
        o_s_stb    = i_m0_stb;
        o_s_we     = i_m0_we;
        o_s_adr    = i_m0_adr;
        o_s_dat_ms = i_m0_dat_ms;
        o_s_sel    = i_m0_sel;
        o_s_cti    = i_m0_cti;
        o_s_bte    = i_m0_bte;
        o_m0_ack   = i_s_ack;
      end
      GNT1: begin
        o_s_cyc    = i_m1_cyc;
        o_s_stb    = i_m1_stb;
        o_s_we     = i_m1_we;
        o_s_adr    = i_m1_adr;
        o_s_dat_ms = i_m1_dat_ms;
        o_s_sel    = i_m1_sel;
        o_s_cti    = i_m1_cti;
        o_s_bte    = i_m1_bte;
        o_m1_ack   = i_s_ack;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_wshb_arbiter_2m.sv
// ============================================================================
// tb_wshb_arbiter_2m : directed bench for wshb_arbiter_2m, round-robin and
//                      fixed-priority instances driven by the same masters.
// ============================================================================
`default_nettype none

module tb_wshb_arbiter_2m;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m_cyc [2];
  logic        m_stb [2];
  logic        m_we  [2];
  logic [31:0] m_adr [2];
  logic [31:0] m_dat [2];
  logic [3:0]  m_sel [2];
  logic [2:0]  m_cti [2];
  logic [1:0]  m_bte [2];
  logic [31:0] s_dat_sm = '0;
  logic        slave_en = 1'b0;
  logic        force_ack = 1'b0;

  wire         m0_ack, m1_ack, s_cyc, s_stb, s_we, s_ack;
  wire  [31:0] m0_dat_sm, m1_dat_sm, s_adr, s_dat_ms;
  wire  [3:0]  s_sel;
  wire  [2:0]  s_cti;
  wire  [1:0]  s_bte, owner;

  wire         f_m0_ack, f_m1_ack, f_cyc, f_stb, f_we, f_ack;
  wire  [31:0] f_m0_dat, f_m1_dat, f_adr, f_dat_ms;
  wire  [3:0]  f_sel;
  wire  [2:0]  f_cti;
  wire  [1:0]  f_bte, f_owner;

  // Slave models: ack every strobed cycle when enabled, or forced regardless.
  assign s_ack = force_ack | (slave_en & s_stb);
  assign f_ack = force_ack | (slave_en & f_stb);

  always #5 clk = ~clk;

  wshb_arbiter_2m #(.MAX_BURST(4), .FIXED_PRIO(1'b0)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .i_m0_cyc(m_cyc[0]), .i_m0_stb(m_stb[0]), .i_m0_we(m_we[0]), .i_m0_adr(m_adr[0]),
    .i_m0_dat_ms(m_dat[0]), .i_m0_sel(m_sel[0]), .i_m0_cti(m_cti[0]), .i_m0_bte(m_bte[0]),
    .o_m0_ack(m0_ack), .o_m0_dat_sm(m0_dat_sm),
    .i_m1_cyc(m_cyc[1]), .i_m1_stb(m_stb[1]), .i_m1_we(m_we[1]), .i_m1_adr(m_adr[1]),
    .i_m1_dat_ms(m_dat[1]), .i_m1_sel(m_sel[1]), .i_m1_cti(m_cti[1]), .i_m1_bte(m_bte[1]),
    .o_m1_ack(m1_ack), .o_m1_dat_sm(m1_dat_sm),
    .o_s_cyc(s_cyc), .o_s_stb(s_stb), .o_s_we(s_we), .o_s_adr(s_adr), .o_s_dat_ms(s_dat_ms),
    .o_s_sel(s_sel), .o_s_cti(s_cti), .o_s_bte(s_bte),
    .i_s_ack(s_ack), .i_s_dat_sm(s_dat_sm), .o_owner(owner)
  );

  wshb_arbiter_2m #(.MAX_BURST(4), .FIXED_PRIO(1'b1)) u_fx (
    .clk(clk), .rst_n(rst_n),
    .i_m0_cyc(m_cyc[0]), .i_m0_stb(m_stb[0]), .i_m0_we(m_we[0]), .i_m0_adr(m_adr[0]),
    .i_m0_dat_ms(m_dat[0]), .i_m0_sel(m_sel[0]), .i_m0_cti(m_cti[0]), .i_m0_bte(m_bte[0]),
    .o_m0_ack(f_m0_ack), .o_m0_dat_sm(f_m0_dat),
    .i_m1_cyc(m_cyc[1]), .i_m1_stb(m_stb[1]), .i_m1_we(m_we[1]), .i_m1_adr(m_adr[1]),
    .i_m1_dat_ms(m_dat[1]), .i_m1_sel(m_sel[1]), .i_m1_cti(m_cti[1]), .i_m1_bte(m_bte[1]),
    .o_m1_ack(f_m1_ack), .o_m1_dat_sm(f_m1_dat),
    .o_s_cyc(f_cyc), .o_s_stb(f_stb), .o_s_we(f_we), .o_s_adr(f_adr), .o_s_dat_ms(f_dat_ms),
    .o_s_sel(f_sel), .o_s_cti(f_cti), .o_s_bte(f_bte),
    .i_s_ack(f_ack), .i_s_dat_sm(s_dat_sm), .o_owner(f_owner)
  );

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [75:0] mbun(input int x);
    return {m_cyc[x], m_stb[x], m_we[x], m_adr[x], m_dat[x], m_sel[x], m_cti[x], m_bte[x]};
  endfunction

  function automatic logic [75:0] sbun();
    return {s_cyc, s_stb, s_we, s_adr, s_dat_ms, s_sel, s_cti, s_bte};
  endfunction

  task automatic set_req(input int x, input logic on);
    m_cyc[x] = on;
    m_stb[x] = on;
    if (x == 0) begin
      q0.delete();
      if (on) q0.push_back(m_adr[0]);
    end else begin
      q1.delete();
      if (on) q1.push_back(m_adr[1]);
    end
  endtask

  task automatic pop_cmp(input int x);
    logic [31:0] e;
    e = '0;
    if (x == 0) begin
      check("sb0_nonempty", 128'(q0.size() != 0), 128'(1));
      if (q0.size() != 0) e = q0.pop_front();
    end else begin
      check("sb1_nonempty", 128'(q1.size() != 0), 128'(1));
      if (q1.size() != 0) e = q1.pop_front();
    end
    check(x == 0 ? "ack0_adr" : "ack1_adr", 128'(s_adr), 128'(e));
  endtask

  // One bus cycle: check this cycle's outputs, then let the acked masters advance.
  task automatic step(input logic [1:0] e_rr, input logic [1:0] e_fx, input logic [1:0] e_ack);
    logic [1:0] done;
    s_dat_sm = $urandom;
    #1;
    check("owner_rr", 128'(owner), 128'(e_rr));
    check("owner_fx", 128'(f_owner), 128'(e_fx));
    check("acks_rr", 128'({m1_ack, m0_ack}), 128'(e_ack));
    check("dat_sm", 128'({m0_dat_sm, m1_dat_sm}), 128'({s_dat_sm, s_dat_sm}));
    if (e_rr == 2'b01)      check("s_mux_m0", 128'(sbun()), 128'(mbun(0)));
    else if (e_rr == 2'b10) check("s_mux_m1", 128'(sbun()), 128'(mbun(1)));
    else                    check("s_idle", 128'(sbun()), 128'(0));
    done = {m1_ack & m_stb[1], m0_ack & m_stb[0]};
    for (int x = 0; x < 2; x++) if (done[x]) pop_cmp(x);
    @(posedge clk);
    #1;
    for (int x = 0; x < 2; x++) begin
      if (done[x]) begin
        m_adr[x] = m_adr[x] + 32'd4;
        m_dat[x] = m_adr[x] ^ 32'hA5A5_5A5A;
        if (x == 0) q0.push_back(m_adr[0]);
        else        q1.push_back(m_adr[1]);
      end
    end
  endtask

  task automatic do_reset();
    set_req(0, 1'b0);
    set_req(1, 1'b0);
    rst_n     = 1'b0;
    force_ack = 1'b1;
    #1;
    check("rst_owner", 128'({owner, f_owner}), 128'(0));
    check("rst_acks", 128'({m0_ack, m1_ack, f_m0_ack, f_m1_ack}), 128'(0));
    check("rst_s_bus", 128'(sbun()), 128'(0));
    @(posedge clk);
    @(posedge clk);
    #1;
    force_ack = 1'b0;
    rst_n     = 1'b1;
  endtask

  initial begin
    m_we[0]  = 1'b0;  m_sel[0] = 4'hF; m_cti[0] = 3'b010; m_bte[0] = 2'b00;
    m_we[1]  = 1'b1;  m_sel[1] = 4'h3; m_cti[1] = 3'b111; m_bte[1] = 2'b01;
    m_adr[0] = 32'h1000_0000; m_dat[0] = m_adr[0] ^ 32'hA5A5_5A5A;
    m_adr[1] = 32'h2000_0000; m_dat[1] = m_adr[1] ^ 32'hA5A5_5A5A;
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    #2;

    // Both masters request from reset: alternating bursts of four, no idle gap.
    do_reset();
    slave_en = 1'b1;
    set_req(0, 1'b1);
    set_req(1, 1'b1);
    step(2'b00, 2'b00, 2'b00);
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++)
        if (r % 2 == 0) step(2'b01, 2'b01, 2'b01);
        else            step(2'b10, 2'b10, 2'b10);
    step(2'b01, 2'b01, 2'b01);
    step(2'b01, 2'b01, 2'b01);
    set_req(0, 1'b0);
    set_req(1, 1'b0);
    step(2'b01, 2'b01, 2'b00);
    step(2'b00, 2'b00, 2'b00);

    // Tie after M0 was last: round-robin picks M1, fixed priority picks M0.
    set_req(0, 1'b1);
    set_req(1, 1'b1);
    step(2'b00, 2'b00, 2'b00);
    for (int k = 0; k < 4; k++) step(2'b10, 2'b01, 2'b10);
    for (int k = 0; k < 4; k++) step(2'b01, 2'b10, 2'b01);
    for (int k = 0; k < 4; k++) step(2'b10, 2'b01, 2'b10);

    // Lone M1: grant after one cycle, counter wraps without an owner change.
    do_reset();
    set_req(1, 1'b1);
    step(2'b00, 2'b00, 2'b00);
    for (int k = 0; k < 10; k++) step(2'b10, 2'b10, 2'b10);

    // M0 drops cyc after two acks; M1 takes over with a fresh burst count.
    do_reset();
    set_req(0, 1'b1);
    step(2'b00, 2'b00, 2'b00);
    step(2'b01, 2'b01, 2'b01);
    step(2'b01, 2'b01, 2'b01);
    set_req(0, 1'b0);
    set_req(1, 1'b1);
    step(2'b01, 2'b01, 2'b00);
    set_req(0, 1'b1);
    for (int k = 0; k < 4; k++) step(2'b10, 2'b10, 2'b10);
    step(2'b01, 2'b01, 2'b01);

    // M1 in a wait state while M0 requests: no switch, M1 stays on the bus.
    do_reset();
    slave_en = 1'b0;
    set_req(1, 1'b1);
    step(2'b00, 2'b00, 2'b00);
    set_req(0, 1'b1);
    for (int k = 0; k < 10; k++) step(2'b10, 2'b10, 2'b00);
    slave_en = 1'b1;
    step(2'b10, 2'b10, 2'b10);

    // Acks with M1's stb low are forwarded but do not count toward the burst.
    m_stb[1]  = 1'b0;
    force_ack = 1'b1;
    step(2'b10, 2'b10, 2'b10);
    step(2'b10, 2'b10, 2'b10);
    m_stb[1]  = 1'b1;
    force_ack = 1'b0;
    for (int k = 0; k < 3; k++) step(2'b10, 2'b10, 2'b10);
    step(2'b01, 2'b01, 2'b01);

    // Reset pulse during an acked M1 cycle aborts the grant immediately.
    do_reset();
    set_req(1, 1'b1);
    step(2'b00, 2'b00, 2'b00);
    step(2'b10, 2'b10, 2'b10);
    #1;
    check("pre_rst_m1_ack", 128'(m1_ack), 128'(1));
    rst_n = 1'b0;
    #1;
    check("async_owner", 128'({owner, f_owner}), 128'(0));
    check("async_acks", 128'({m1_ack, f_m1_ack}), 128'(0));
    check("async_cyc_stb", 128'({s_cyc, s_stb, f_cyc, f_stb}), 128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(2'b00, 2'b00, 2'b00);
    step(2'b10, 2'b10, 2'b10);
    set_req(1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
